// File: rtl/hsimple_pio_pkg.sv
// Shared definitions for the HSIMPLE PIO register-file responder.
// Holds the responder FSM state type, default constants and the
// address decode helpers used by the top level.
package hsimple_pio_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ACK   = 3'd1,
    RD_WAIT  = 3'd2,
    RD_ACK   = 3'd3,
    WAIT_LOW = 3'd4
  } pioState_t;

  localparam logic [31:0]  BAD_READ_VALUE_DEFAULT = 32'hBADADD00;
  localparam int unsigned  ERR_COUNT_W            = 16;
  // Decode is done at a fixed wide width so any ADDR_W up to 64 fits.
  localparam int unsigned  DECODE_W               = 64;

  // Address hits a register: aligned to the stride and inside the file.
  // Upper address bits take part in the compare, so aliases are rejected.
  function automatic logic addrValid(input logic [DECODE_W-1:0] addr,
                                     input int unsigned stride,
                                     input int unsigned nregs);
    return ((addr % DECODE_W'(stride)) == '0) &&
           ((addr / DECODE_W'(stride)) < DECODE_W'(nregs));
  endfunction

  // Register index of a byte address; only meaningful when addrValid holds.
  function automatic logic [31:0] addrIndex(input logic [DECODE_W-1:0] addr,
                                            input int unsigned stride);
    return 32'(addr / DECODE_W'(stride));
  endfunction

endpackage

// File: rtl/hsimple_pio_regstore.sv
// Register storage for the PIO responder.
// Ports: clk, reset (sync, active-high); we/widx/wdata registered write
// port; ridx -> rdata combinational read mux.
module hsimple_pio_regstore
  import hsimple_pio_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NREGS];

  // Write port; out-of-range indices are ignored for non-power-of-two NREGS.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (32'(widx) < NREGS)) begin
      regs[widx] <= wdata;
    end
  end

  // Read mux.
  always_comb begin
    rdata = '0;
    if (32'(ridx) < NREGS) begin
      rdata = regs[ridx];
    end
  end

endmodule

// File: rtl/hsimple_pio_regfile_responder.sv
// HSIMPLE programmed-I/O register-file responder.
// Serves single-word reads and writes on separate req/ack channels, one
// transaction at a time, each acknowledged with a one-cycle ack pulse.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   pioRegfileRead_addr/_req   read request; _ack pulse, _return data
//   pioRegfileWrite_addr/_data/_req  write request; _ack pulse
//   busy                       FSM not idle
//   err_count                  saturating count of invalid-address accesses
module hsimple_pio_regfile_responder
  import hsimple_pio_pkg::*;
#(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       NREGS          = 8,
  parameter int unsigned       ADDR_STRIDE    = 8,
  parameter int unsigned       READ_LATENCY   = 2,
  parameter logic [DATA_W-1:0] BAD_READ_VALUE = DATA_W'(BAD_READ_VALUE_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      pioRegfileRead_addr,
  input  logic                   pioRegfileRead_req,
  output logic                   pioRegfileRead_ack,
  output logic [DATA_W-1:0]      pioRegfileRead_return,
  input  logic [ADDR_W-1:0]      pioRegfileWrite_addr,
  input  logic [DATA_W-1:0]      pioRegfileWrite_data,
  input  logic                   pioRegfileWrite_req,
  output logic                   pioRegfileWrite_ack,
  output logic                   busy,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned CNT_W = 4;

  pioState_t         state, stateNext;
  logic [CNT_W-1:0]  rdCnt, rdCntNext;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latData;
  logic              latIsWrite;
  logic              acceptWr, acceptRd;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdValid, wrValid;
  logic [IDX_W-1:0]  rdIdx, wrIdx;
  logic [DATA_W-1:0] rdData;
  logic              regWe, errInc;

  // With READ_LATENCY==1 the read is served straight out of IDLE, before
  // the address has been latched, so decode the live bus in that state.
  assign rdAddr  = (state == IDLE) ? pioRegfileRead_addr : latAddr;
  assign rdValid = addrValid(DECODE_W'(rdAddr), ADDR_STRIDE, NREGS);
  assign rdIdx   = IDX_W'(addrIndex(DECODE_W'(rdAddr), ADDR_STRIDE));
  assign wrValid = addrValid(DECODE_W'(latAddr), ADDR_STRIDE, NREGS);
  assign wrIdx   = IDX_W'(addrIndex(DECODE_W'(latAddr), ADDR_STRIDE));

  // Commit on the edge leaving WR_ACK; invalid accesses bump the error count.
  assign regWe  = (state == WR_ACK) && wrValid;
  assign errInc = ((state == WR_ACK) && !wrValid) ||
                  ((stateNext == RD_ACK) && !rdValid);

  hsimple_pio_regstore #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) uRegStore (
    .clk   (clk),
    .reset (reset),
    .we    (regWe),
    .widx  (wrIdx),
    .wdata (latData),
    .ridx  (rdIdx),
    .rdata (rdData)
  );

  // Next-state logic.
  always_comb begin
    stateNext = state;
    rdCntNext = rdCnt;
    acceptWr  = 1'b0;
    acceptRd  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pioRegfileWrite_req) begin
          acceptWr  = 1'b1;
          stateNext = WR_ACK;
        end else if (pioRegfileRead_req) begin
          acceptRd  = 1'b1;
          rdCntNext = CNT_W'(READ_LATENCY - 1);
          stateNext = (READ_LATENCY <= 1) ? RD_ACK : RD_WAIT;
        end
      end
      WR_ACK: stateNext = WAIT_LOW;
      RD_WAIT: begin
        rdCntNext = rdCnt - CNT_W'(1);
        if (rdCnt == CNT_W'(1)) begin
          stateNext = RD_ACK;
        end
      end
      RD_ACK: stateNext = WAIT_LOW;
      WAIT_LOW: begin
        // Release only once the channel just served has dropped its req.
        if (latIsWrite ? !pioRegfileWrite_req : !pioRegfileRead_req) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, latches and registered outputs (outputs track the next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      rdCnt                 <= '0;
      latAddr               <= '0;
      latData               <= '0;
      latIsWrite            <= 1'b0;
      pioRegfileWrite_ack   <= 1'b0;
      pioRegfileRead_ack    <= 1'b0;
      pioRegfileRead_return <= '0;
      busy                  <= 1'b0;
      err_count             <= '0;
    end else begin
      state <= stateNext;
      rdCnt <= rdCntNext;
      if (acceptWr) begin
        latAddr    <= pioRegfileWrite_addr;
        latData    <= pioRegfileWrite_data;
        latIsWrite <= 1'b1;
      end else if (acceptRd) begin
        latAddr    <= pioRegfileRead_addr;
        latIsWrite <= 1'b0;
      end
      pioRegfileWrite_ack <= (stateNext == WR_ACK);
      pioRegfileRead_ack  <= (stateNext == RD_ACK);
      busy                <= (stateNext != IDLE);
      if (stateNext == RD_ACK) begin
        pioRegfileRead_return <= rdValid ? rdData : BAD_READ_VALUE;
      end
      if (errInc && (err_count != '1)) begin
        err_count <= err_count + ERR_COUNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hsimple_pio_regfile_responder.md
Name: hsimple_pio_regfile_responder

Overview:
- Target (responder) end of the HSIMPLE programmed-I/O register-file protocol.
- Accepts single-word write and read requests from an off-chip or testbench initiator on separate req/ack channels.
- Holds a small register file and acknowledges each request with a one-cycle ack pulse.
- Sits inside the Kiwi substrate as the PIO endpoint that test wrappers and host shims drive.

Parameters:
- DATA_W, 32, data width of registers and of the write-data/read-return buses.
- ADDR_W, 32, width of the byte-address buses.
- NREGS, 8, number of registers implemented.
- ADDR_STRIDE, 8, byte spacing between registers (a power of two); register index = addr / ADDR_STRIDE.
- READ_LATENCY, 2, cycles from read acceptance to read ack; legal values are 1..15.
- BAD_READ_VALUE, 32'hBADADD00, value returned for an invalid read address.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pioRegfileRead_addr  in  ADDR_W  read byte address; stable while read req is high.
- pioRegfileRead_req  in  1  read request; held by the initiator until it samples ack.
- pioRegfileRead_ack  out  1  one-cycle read acknowledge.
- pioRegfileRead_return  out  DATA_W  read data; valid in the ack cycle and held until the next read ack.
- pioRegfileWrite_addr  in  ADDR_W  write byte address.
- pioRegfileWrite_data  in  DATA_W  write data.
- pioRegfileWrite_req  in  1  write request.
- pioRegfileWrite_ack  out  1  one-cycle write acknowledge.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_count  out  16  count of invalid-address accesses; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: both acks 0, pioRegfileRead_return 0, all registers 0, err_count 0, busy 0, FSM in IDLE. Reset asserted mid-transaction aborts it: no ack is issued and any pending write is discarded.
- Address decode: an address is valid iff addr % ADDR_STRIDE == 0 and addr / ADDR_STRIDE < NREGS. Upper address bits beyond the index are not ignored; for example, an addr of NREGS*ADDR_STRIDE is invalid.
- FSM states: IDLE, WR_ACK, RD_WAIT, RD_ACK, WAIT_LOW. A single FSM serves both channels, so only one transaction is outstanding at a time.
- IDLE:
  - If write req is high, latch addr and data and go to WR_ACK. Write has priority when both reqs are high in the same cycle.
  - Otherwise, if read req is high, latch addr, load the latency counter with READ_LATENCY-1, and go to RD_WAIT, or go directly to RD_ACK when READ_LATENCY==1.
- WR_ACK:
  - pioRegfileWrite_ack=1 for exactly this cycle.
  - On the edge leaving this state, a valid write updates its register; an invalid write is dropped and err_count increments.
  - Next state is WAIT_LOW. Write latency is therefore 1 cycle from acceptance to ack.
- RD_WAIT: decrement the counter; go to RD_ACK when it reaches 0.
- RD_ACK:
  - pioRegfileRead_ack=1 for exactly this cycle.
  - pioRegfileRead_return is registered so that it presents the register value (or BAD_READ_VALUE on an invalid address) in this same cycle; an invalid read also increments err_count.
  - The read samples register contents at entry to RD_ACK.
  - Next state is WAIT_LOW.
- WAIT_LOW: stay until the req of the just-served channel is 0, then go to IDLE. This guarantees that a held req is never acknowledged twice. The other channel's req may be high here; it is served from IDLE on the next cycle.
- Acks are never asserted outside WR_ACK and RD_ACK. The responder does not care whether data/addr change after ack.
- Back-to-back: an initiator that drops req in the cycle after ack sees a minimum of 3 cycles per write (accept, ack, wait_low) and READ_LATENCY+2 cycles per read.

Decomposition:
- Package hsimple_pio_pkg holds:
  - the FSM state enum;
  - the default BAD_READ_VALUE and ERR_COUNT_W=16 constants;
  - an addr_valid/addr_index function pair parameterised by ADDR_STRIDE and NREGS.
- One sub-module, hsimple_pio_regstore: NREGS x DATA_W flops with a registered write port (we, widx, wdata) and a combinational read mux (ridx -> rdata), plus synchronous reset to zero.
- The FSM, latency counter and error counter stay in the top-level module.

Test Plan:
- Write and read back: write addr 8 = 32'hDEADBEEF at cycle 10, write addr 16 = 32'h12345678 at cycle 20, read addr 8 at 30, read addr 16 at 40 -> returns DEADBEEF then 12345678; each ack high exactly 1 cycle; read ack exactly READ_LATENCY cycles after acceptance.
- Simultaneous reqs: write addr 0 = 32'hA5A5A5A5 and read addr 0 raised in the same cycle -> write acked first, read acked afterwards and returns A5A5A5A5.
- Held req: initiator holds write req high for 10 cycles after ack -> exactly one ack pulse, FSM stays in WAIT_LOW, busy=1 until req drops.
- Invalid addresses: read addr 12 (misaligned) and write addr 64 with NREGS=8 -> read returns 32'hBADADD00, write changes no register, err_count=2, both requests still acked.
- Reset mid-read: assert reset while in RD_WAIT with READ_LATENCY=4 -> no ack issued, return=0, all registers 0; the next read of addr 8 returns 0.
- Latency sweep: READ_LATENCY=1 and READ_LATENCY=15 -> read ack exactly 1 and 15 cycles after acceptance respectively.
